// File: rtl/cnt_sweep_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cnt_sweep_ctrl
// Description : Sequencer for a bounded 4-bit up/down counter. Sweeps
//               MIN->MAX->MIN for a programmed number of repetitions with a
//               DWELL-cycle hold at each turnaround, and reports progress via
//               busy / done / aborted.
// Revision    : 1.0 - initial release
// ============================================================================
module cnt_sweep_ctrl #(
    parameter int MAX   = 15,
    parameter int MIN   = 0,
    parameter int DWELL = 3,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [REP_W-1:0] reps,
    input  logic             abort,
    output logic [3:0]       cnt,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [REP_W-1:0] sweeps_left
);

    // Dwell counter is at least one bit wide even when holds are disabled.
    localparam int                c_DW_W    = (DWELL > 0) ? $clog2(DWELL + 1) : 1;
    localparam logic [3:0]        c_MAX     = 4'(MAX);
    localparam logic [3:0]        c_MIN     = 4'(MIN);
    localparam logic [c_DW_W-1:0] c_DW_LAST = c_DW_W'((DWELL > 0) ? DWELL - 1 : 0);
    localparam logic [REP_W-1:0]  c_ONE_REP = REP_W'(1);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_UP      = 3'd1;
    localparam logic [2:0] c_HOLD_HI = 3'd2;
    localparam logic [2:0] c_DOWN    = 3'd3;
    localparam logic [2:0] c_HOLD_LO = 3'd4;
    localparam logic [2:0] c_DONE    = 3'd5;

    logic [2:0]        r_state;
    logic [3:0]        r_cnt;
    logic [REP_W-1:0]  r_sweeps;
    logic [c_DW_W-1:0] r_dwell;
    logic              r_aborted;

    logic [2:0]        w_state_nxt;
    logic [3:0]        w_cnt_nxt;
    logic [REP_W-1:0]  w_sweeps_nxt;
    logic [c_DW_W-1:0] w_dwell_nxt;
    logic              w_aborted_nxt;
    logic              w_active;

    // Active sweep states are the only ones where abort is honoured.
    assign w_active = (r_state == c_UP) || (r_state == c_HOLD_HI) ||
                      (r_state == c_DOWN) || (r_state == c_HOLD_LO);

    // Next-state and datapath update; abort overrides every other transition.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_sweeps_nxt  = r_sweeps;
        w_dwell_nxt   = r_dwell;
        w_aborted_nxt = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_cnt_nxt = c_MIN;
                if (start && (reps != '0)) begin
                    w_state_nxt  = c_UP;
                    w_sweeps_nxt = reps;
                end
            end
            c_UP: begin
                if (r_cnt != c_MAX) begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end else if (DWELL == 0) begin
                    w_state_nxt = c_DOWN;
                end else begin
                    w_state_nxt = c_HOLD_HI;
                    w_dwell_nxt = '0;
                end
            end
            c_HOLD_HI: begin
                if (r_dwell == c_DW_LAST) begin
                    w_state_nxt = c_DOWN;
                    w_dwell_nxt = '0;
                end else begin
                    w_dwell_nxt = r_dwell + 1'b1;
                end
            end
            c_DOWN: begin
                if (r_cnt != c_MIN) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else if (r_sweeps == c_ONE_REP) begin
                    w_state_nxt  = c_DONE;
                    w_sweeps_nxt = '0;
                end else begin
                    w_sweeps_nxt = r_sweeps - 1'b1;
                    if (DWELL == 0) begin
                        w_state_nxt = c_UP;
                    end else begin
                        w_state_nxt = c_HOLD_LO;
                        w_dwell_nxt = '0;
                    end
                end
            end
            c_HOLD_LO: begin
                if (r_dwell == c_DW_LAST) begin
                    w_state_nxt = c_UP;
                    w_dwell_nxt = '0;
                end else begin
                    w_dwell_nxt = r_dwell + 1'b1;
                end
            end
            c_DONE: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_cnt_nxt   = c_MIN;
            end
        endcase
        if (abort && w_active) begin
            w_state_nxt   = c_IDLE;
            w_cnt_nxt     = c_MIN;
            w_sweeps_nxt  = '0;
            w_dwell_nxt   = '0;
            w_aborted_nxt = 1'b1;
        end
    end

    // State and datapath registers with asynchronous return to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_cnt     <= c_MIN;
            r_sweeps  <= '0;
            r_dwell   <= '0;
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_sweeps  <= w_sweeps_nxt;
            r_dwell   <= w_dwell_nxt;
            r_aborted <= w_aborted_nxt;
        end
    end

    assign cnt         = r_cnt;
    assign sweeps_left = r_sweeps;
    assign aborted     = r_aborted;
    assign busy        = w_active;
    assign done        = (r_state == c_DONE);
    assign dir         = (r_state == c_HOLD_HI) || (r_state == c_DOWN);

endmodule
`default_nettype wire

// File: tb/tb_cnt_sweep_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_cnt_sweep_ctrl
// Description : Scoreboard bench for cnt_sweep_ctrl. Two instances: default
//               parameters, and MIN=2 / MAX=5 / DWELL=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cnt_sweep_ctrl;

    typedef struct packed {
        logic [3:0] cnt;
        logic       dir;
        logic       busy;
        logic       done;
        logic       aborted;
        logic [3:0] sw;
    } obs_t;

    logic       clk;
    logic       rst_n;
    logic       start0, abort0, start1, abort1;
    logic [3:0] reps0, reps1;
    logic [3:0] cnt0, cnt1, sw0, sw1;
    logic       dir0, busy0, done0, aborted0;
    logic       dir1, busy1, done1, aborted1;

    int   total = 0;
    int   bad   = 0;
    obs_t q0[$];
    obs_t q1[$];
    obs_t m0_got, m0_exp, m1_got, m1_exp;

    cnt_sweep_ctrl u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .reps(reps0), .abort(abort0),
        .cnt(cnt0), .dir(dir0), .busy(busy0), .done(done0), .aborted(aborted0),
        .sweeps_left(sw0)
    );

    cnt_sweep_ctrl #(.MAX(5), .MIN(2), .DWELL(0), .REP_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .reps(reps1), .abort(abort1),
        .cnt(cnt1), .dir(dir1), .busy(busy1), .done(done1), .aborted(aborted1),
        .sweeps_left(sw1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t mk(input int c, input int d, input int b,
                                input int dn, input int a, input int s);
        obs_t o;
        o.cnt     = 4'(c);
        o.dir     = 1'(d);
        o.busy    = 1'(b);
        o.done    = 1'(dn);
        o.aborted = 1'(a);
        o.sw      = 4'(s);
        return o;
    endfunction

    function automatic int lo_of(input int which);
        return (which == 0) ? 0 : 2;
    endfunction
    function automatic int hi_of(input int which);
        return (which == 0) ? 15 : 5;
    endfunction
    function automatic int dw_of(input int which);
        return (which == 0) ? 3 : 0;
    endfunction

    function automatic int qsize(input int which);
        return (which == 0) ? q0.size() : q1.size();
    endfunction

    function automatic int seq_len(input int which, input int r);
        return r * (2 * (hi_of(which) - lo_of(which) + 1) + dw_of(which))
               + (r - 1) * dw_of(which) + 1;
    endfunction

    task automatic push_one(input int which, input obs_t o);
        if (which == 0) q0.push_back(o);
        else            q1.push_back(o);
    endtask

    task automatic flush(input int which);
        if (which == 0) q0.delete();
        else            q1.delete();
    endtask

    // Expected per-cycle observation stream for a full sequence of r sweeps.
    task automatic push_seq(input int which, input int r);
        int lo, hi, dw;
        lo = lo_of(which);
        hi = hi_of(which);
        dw = dw_of(which);
        for (int s = r; s >= 1; s--) begin
            for (int v = lo; v <= hi; v++) push_one(which, mk(v, 0, 1, 0, 0, s));
            for (int k = 0; k < dw; k++)   push_one(which, mk(hi, 1, 1, 0, 0, s));
            for (int v = hi; v >= lo; v--) push_one(which, mk(v, 1, 1, 0, 0, s));
            if (s > 1)
                for (int k = 0; k < dw; k++) push_one(which, mk(lo, 0, 1, 0, 0, s - 1));
        end
        push_one(which, mk(lo, 0, 0, 1, 0, 0));
    endtask

    task automatic check(input string nm, input obs_t got, input obs_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got cnt=%0d dir=%0b busy=%0b done=%0b ab=%0b sw=%0d want cnt=%0d dir=%0b busy=%0b done=%0b ab=%0b sw=%0d",
                     nm, $time, got.cnt, got.dir, got.busy, got.done, got.aborted, got.sw,
                     exp.cnt, exp.dir, exp.busy, exp.done, exp.aborted, exp.sw);
        end
    endtask

    task automatic drive(input int which, input logic s, input logic [3:0] r, input logic a);
        if (which == 0) begin start0 = s; reps0 = r; abort0 = a; end
        else            begin start1 = s; reps1 = r; abort1 = a; end
    endtask

    // Monitors: one observation per cycle; idle expected when nothing queued.
    always @(negedge clk) begin
        m0_got = {cnt0, dir0, busy0, done0, aborted0, sw0};
        if (q0.size() > 0) m0_exp = q0.pop_front();
        else               m0_exp = mk(0, 0, 0, 0, 0, 0);
        check("dut0_obs", m0_got, m0_exp);
    end

    always @(negedge clk) begin
        m1_got = {cnt1, dir1, busy1, done1, aborted1, sw1};
        if (q1.size() > 0) m1_exp = q1.pop_front();
        else               m1_exp = mk(2, 0, 0, 0, 0, 0);
        check("dut1_obs", m1_got, m1_exp);
    end

    // Start pulse for one cycle; reps=0 produces no expected activity.
    task automatic issue_start(input int which, input int r, input logic with_abort);
        @(negedge clk); #1;
        drive(which, 1'b1, 4'(r), with_abort);
        if (r != 0) push_seq(which, r);
        @(negedge clk); #1;
        drive(which, 1'b0, 4'd0, 1'b0);
    endtask

    // Runs until the expected stream drains; optional abort after abort_at
    // observations and optional start/reps noise while busy.
    task automatic run_seq(input int which, input int abort_at, input bit noise);
        int n, budget;
        n = 1;
        budget = 0;
        while (qsize(which) > 0) begin
            if (abort_at != 0 && n == abort_at) begin
                drive(which, 1'b0, 4'd0, 1'b1);
                flush(which);
                push_one(which, mk(lo_of(which), 0, 0, 0, 1, 0));
            end else if (noise && qsize(which) > 1 && $urandom_range(0, 3) == 0) begin
                drive(which, 1'b1, 4'($urandom), 1'b0);
            end else begin
                drive(which, 1'b0, 4'($urandom), 1'b0);
            end
            @(negedge clk); #1;
            n++;
            budget++;
            if (budget > 1000) begin
                total++;
                bad++;
                $display("FAIL timeout dut%0d got %0d pending want 0", which, qsize(which));
                flush(which);
                break;
            end
        end
        drive(which, 1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        int r, ab;
        rst_n = 1'b0;
        start0 = 1'b0; abort0 = 1'b0; reps0 = 4'd0;
        start1 = 1'b0; abort1 = 1'b0; reps1 = 4'd0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Single sweep, then start while in DONE (ignored).
        issue_start(0, 1, 1'b0);
        run_seq(0, 0, 1'b0);
        drive(0, 1'b1, 4'd1, 1'b0);
        @(negedge clk); #1;
        drive(0, 1'b0, 4'd0, 1'b0);
        repeat (2) @(negedge clk);

        // Three sweeps with start/reps noise, then abort while in DONE.
        issue_start(0, 3, 1'b0);
        run_seq(0, 0, 1'b1);
        drive(0, 1'b0, 4'd0, 1'b1);
        @(negedge clk); #1;
        drive(0, 1'b0, 4'd0, 1'b0);

        // Abort in second HOLD_HI cycle, then a normal restart.
        issue_start(0, 2, 1'b0);
        run_seq(0, 18, 1'b0);
        issue_start(0, 1, 1'b0);
        run_seq(0, 0, 1'b0);

        // reps=0 start ignored; abort in IDLE ignored; start+abort in IDLE starts.
        issue_start(0, 0, 1'b0);
        repeat (3) @(negedge clk);
        #1 drive(0, 1'b0, 4'd0, 1'b1);
        repeat (2) @(negedge clk);
        #1 drive(0, 1'b0, 4'd0, 1'b0);
        issue_start(0, 2, 1'b1);
        run_seq(0, 0, 1'b0);

        // Randomized sequences with optional aborts.
        for (int i = 0; i < 5; i++) begin
            r  = $urandom_range(1, 3);
            ab = ($urandom_range(0, 1) == 1) ? $urandom_range(1, seq_len(0, r) - 1) : 0;
            issue_start(0, r, 1'b0);
            run_seq(0, ab, 1'b1);
        end

        // Asynchronous reset while counting down.
        issue_start(0, 1, 1'b0);
        repeat (24) @(negedge clk);
        #1 rst_n = 1'b0;
        flush(0);
        #1 check("async_reset", {cnt0, dir0, busy0, done0, aborted0, sw0}, mk(0, 0, 0, 0, 0, 0));
        @(negedge clk); #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // DWELL=0 instance: fixed two-sweep sequence then random runs.
        issue_start(1, 2, 1'b0);
        run_seq(1, 0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            r  = $urandom_range(1, 4);
            ab = ($urandom_range(0, 1) == 1) ? $urandom_range(1, seq_len(1, r) - 1) : 0;
            issue_start(1, r, 1'b0);
            run_seq(1, ab, 1'b1);
        end

        repeat (4) @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
